// File: rtl/led_count_monitor.sv
// led_count_monitor: watches an LED counter word and checks that it advances by exactly one
// per step at a steady rate of enabled cycles, flagging sticky value and timing errors.
module led_count_monitor #(
    parameter int EXT_CLOCK_FREQ = 50000000,
    parameter int LEDG_SIZE      = 8,
    parameter int TICKS_PER_STEP = EXT_CLOCK_FREQ / 5,
    parameter int TOL            = 2
) (
    input  logic                 EXTCLK,
    input  logic                 RST,
    input  logic [LEDG_SIZE-1:0] LED_IN,
    input  logic                 ENABLE,
    output logic                 LOCKED,
    output logic                 STEP_PULSE,
    output logic [15:0]          STEP_CNT,
    output logic [31:0]          LAST_PERIOD,
    output logic                 ERR_VALUE,
    output logic                 ERR_TIMING
);
    localparam int CW = LEDG_SIZE - 1;
    localparam logic [31:0] LO = 32'(TICKS_PER_STEP - TOL);
    localparam logic [31:0] HI = 32'(TICKS_PER_STEP + TOL);

    typedef enum logic {IDLE, TRACK} state_t;

    state_t               state_q, state_d;
    logic [LEDG_SIZE-1:0] prev_q;
    logic [LEDG_SIZE-1:0] expected;
    logic [31:0]          pcnt_q, pcnt_d, last_q, last_d, step_len;
    logic [15:0]          cnt_q, cnt_d;
    logic                 pulse_q, pulse_d, errv_q, errv_d, errt_q, errt_d;
    logic                 change;

    assign change   = LED_IN != prev_q;
    assign expected = {prev_q[CW] ^ (&prev_q[CW-1:0]), prev_q[CW-1:0] + CW'(1)};
    assign step_len = (pcnt_q == '1) ? pcnt_q : pcnt_q + 32'd1;

    always_comb begin
        state_d = state_q;
        pcnt_d  = change ? '0 : (ENABLE && pcnt_q != '1) ? pcnt_q + 32'd1 : pcnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        errv_d  = errv_q;
        errt_d  = errt_q;
        if (state_q == IDLE) begin
            if (change) begin
                state_d = TRACK;
                cnt_d   = '0;
            end
        end else if (change) begin
            if (!ENABLE) begin
                errv_d = 1'b1;
            end else if (LED_IN == expected) begin
                pulse_d = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                last_d  = step_len;
                if (step_len < LO || step_len > HI) errt_d = 1'b1;
            end else if (LED_IN == '0) begin
                state_d = IDLE;
            end else begin
                errv_d = 1'b1;
            end
        // the counter steps past HI exactly once per interval, so this fires once
        end else if (ENABLE && pcnt_q == HI) begin
            errt_d = 1'b1;
        end
    end

    always_ff @(posedge EXTCLK) begin
        prev_q <= LED_IN;
        if (RST) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            errv_q  <= 1'b0;
            errt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            errv_q  <= errv_d;
            errt_q  <= errt_d;
        end
    end

    assign LOCKED      = state_q == TRACK;
    assign STEP_PULSE  = pulse_q;
    assign STEP_CNT    = cnt_q;
    assign LAST_PERIOD = last_q;
    assign ERR_VALUE   = errv_q;
    assign ERR_TIMING  = errt_q;
endmodule

// File: tb/tb_led_count_monitor.sv
// tb_led_count_monitor: directed and random LED sequences scored against a cycle-level
// model of the counter-watching rules; a monitor compares outputs independently of stimulus.
module tb_led_count_monitor;
    localparam int T  = 10;
    localparam int TL = 1;
    localparam int W  = 8;

    typedef struct packed {
        logic        locked;
        logic        pulse;
        logic [15:0] cnt;
        logic [31:0] last;
        logic        ev;
        logic        et;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [W-1:0] led = '0;
    logic         locked, pulse, ev, et;
    logic [15:0]  cnt;
    logic [31:0]  last;

    int checks = 0;
    int passed = 0;

    obs_t        exp_q[$];
    logic [47:0] step_q[$];
    obs_t        mon_e, mon_a;
    logic [47:0] mon_s;

    logic [W-1:0] m_prev = '0;
    bit           m_locked, m_ev, m_et;
    int           m_elapsed, m_steps, m_last;

    always #5 clk = ~clk;

    led_count_monitor #(
        .EXT_CLOCK_FREQ(50),
        .LEDG_SIZE(W),
        .TICKS_PER_STEP(T),
        .TOL(TL)
    ) dut (
        .EXTCLK(clk),
        .RST(rst),
        .LED_IN(led),
        .ENABLE(en),
        .LOCKED(locked),
        .STEP_PULSE(pulse),
        .STEP_CNT(cnt),
        .LAST_PERIOD(last),
        .ERR_VALUE(ev),
        .ERR_TIMING(et)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    endtask

    // Drive one cycle of inputs and predict the outputs after the next rising edge.
    task automatic cyc(input logic [W-1:0] l, input logic e, input logic r);
        bit p;
        @(negedge clk);
        led = l;
        en  = e;
        rst = r;
        p   = 1'b0;
        if (r) begin
            m_locked = 0; m_ev = 0; m_et = 0;
            m_elapsed = 0; m_steps = 0; m_last = 0;
        end else if (l != m_prev) begin
            if (!m_locked) begin
                m_locked = 1;
                m_steps  = 0;
            end else if (!e) begin
                m_ev = 1;
            end else if (l == W'(m_prev + 1)) begin
                p       = 1'b1;
                m_steps = (m_steps + 1) % 65536;
                m_last  = m_elapsed + 1;
                if (m_last < T - TL || m_last > T + TL) m_et = 1;
                step_q.push_back({16'(m_steps), 32'(m_last)});
            end else if (l == 0) begin
                m_locked = 0;
            end else begin
                m_ev = 1;
            end
            m_elapsed = 0;
        end else if (e) begin
            m_elapsed++;
            if (m_locked && m_elapsed == T + TL + 1) m_et = 1;
        end
        m_prev = l;
        exp_q.push_back('{m_locked, p, 16'(m_steps), 32'(m_last), m_ev, m_et});
    endtask

    task automatic hold(input logic [W-1:0] l, input logic e, input int n);
        for (int i = 0; i < n; i++) cyc(l, e, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {locked, pulse, cnt, last, ev, et};
            chk("outputs", 64'(mon_a), 64'(mon_e));
        end
        if (pulse) begin
            if (step_q.size() == 0) begin
                chk("unexpected_step", 64'({cnt, last}), 64'hDEAD);
            end else begin
                mon_s = step_q.pop_front();
                chk("step_record", 64'({cnt, last}), 64'(mon_s));
            end
        end
    end

    logic [W-1:0] cur, nxt;
    int n, r;

    initial begin
        // reset with a static word
        hold(8'h00, 1'b0, 3);
        for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0, 1'b1);
        // basic stepping
        hold(8'h00, 1'b1, 10);
        hold(8'h01, 1'b1, 10);
        hold(8'h02, 1'b1, 10);
        hold(8'h03, 1'b1, 10);
        // overflow bit crossing
        cyc(8'h7D, 1'b1, 1'b1);
        hold(8'h7D, 1'b1, 5);
        hold(8'h7E, 1'b1, 10);
        hold(8'h7F, 1'b1, 10);
        hold(8'h80, 1'b1, 10);
        hold(8'h81, 1'b1, 10);
        // late step, long hold, value jump
        cyc(8'h03, 1'b1, 1'b1);
        hold(8'h03, 1'b1, 10);
        hold(8'h04, 1'b1, 14);
        hold(8'h05, 1'b1, 13);
        hold(8'h09, 1'b1, 10);
        hold(8'h0A, 1'b1, 10);
        // enable gap mid-interval, then change while disabled
        cyc(8'h10, 1'b1, 1'b1);
        hold(8'h10, 1'b1, 4);
        hold(8'h11, 1'b1, 5);
        hold(8'h11, 1'b0, 20);
        hold(8'h11, 1'b1, 5);
        hold(8'h12, 1'b1, 10);
        hold(8'h13, 1'b0, 3);
        // return to zero unlocks, then reset while tracking
        cyc(8'h22, 1'b1, 1'b1);
        hold(8'h22, 1'b1, 3);
        hold(8'h23, 1'b1, 10);
        hold(8'h00, 1'b1, 5);
        hold(8'h01, 1'b1, 4);
        cyc(8'h01, 1'b1, 1'b1);
        hold(8'h01, 1'b1, 3);
        // random intervals, values and enables
        cur = 8'hFC;
        cyc(cur, 1'b1, 1'b1);
        for (int k = 0; k < 150; k++) begin
            n = $urandom_range(8, 13);
            r = $urandom_range(0, 99);
            if (r < 3) cyc(cur, 1'b1, 1'b1);
            nxt = (r < 70) ? W'(cur + 1'b1) : (r < 78) ? '0 : (r < 90) ? W'($urandom) : W'(cur + 1'b1);
            cyc(nxt, r < 95, 1'b0);
            for (int i = 1; i < n; i++) cyc(nxt, $urandom_range(0, 9) != 0, 1'b0);
            cur = nxt;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("queues_drained", 64'(exp_q.size() + step_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
